// File: rtl/vip_discount_store_pkg.sv
// Shared definitions for the VIP discount store and the manager VIP menu:
// manager command encodings, compute FSM states, default parameter values
// and the legality check for a requested discount factor.
package vip_discount_store_pkg;

  localparam int unsigned PRICE_W_DEF  = 14;
  localparam int unsigned OFF_NONE_DEF = 10;
  localparam int unsigned CNT_MAX_DEF  = 99;

  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_REV  = 2'b01,
    CMD_RSV  = 2'b10,
    CMD_SET  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_e;

  // A settable factor is a real discount: 1 .. off_none-1.
  function automatic logic off_legal(input logic [4:0] value, input logic [4:0] off_none);
    return (value != 5'd0) && (value < off_none);
  endfunction

endpackage

// File: rtl/vip_discount_store_div10_serial.sv
// Serial restoring divider by 10, one quotient bit per clock, MSB first.
// Ports:
//   clk, rst   clock, synchronous active-high reset (aborts a division)
//   start      load dividend and begin; ignored bits of a running division
//   dividend   W-bit unsigned value to divide
//   busy       division in progress
//   done       1-cycle pulse, quotient valid (W cycles after start is sampled)
//   quotient   floor(dividend/10), held until the next start
module div10_serial #(
  parameter int unsigned W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int unsigned CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [4:0]    rem;
  logic [W-1:0]  q;
  logic [CW-1:0] cnt;
  logic [5:0]    trial;
  logic          ge;
  logic [4:0]    rem_nxt;

  // Remainder stays below 10, so the shifted trial value fits in 6 bits.
  always_comb begin
    trial   = {rem, q[W-1]};
    ge      = (trial >= 6'd10);
    rem_nxt = ge ? 5'(trial - 6'd10) : trial[4:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      rem  <= '0;
      q    <= '0;
      cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        rem  <= '0;
        q    <= dividend;
        cnt  <= '0;
      end else if (busy) begin
        q   <= {q[W-2:0], ge};
        rem <= rem_nxt;
        if (cnt == LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign quotient = q;

endmodule

// File: rtl/vip_discount_store.sv
// VIP discount store: holds the VIP discount factor, applies manager
// set/revive commands, and computes price*off/10 for checkout with a fixed
// 23-cycle latency (4-cycle shift-add multiply, 18-cycle serial divide).
// Counts discounted VIP sales, saturating at CNT_MAX.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en, wr_cmd      manager command strobe and code (00 none, 11 set, 01 revive, 10 reserved)
//   vip_off_i       factor for a set command (legal 1..9)
//   vip_off_o       current factor, to manager display
//   wr_err          1-cycle pulse for illegal set value or reserved command
//   req_valid/ready checkout request handshake (ready only when idle)
//   req_price       list price; req_is_vip selects the VIP factor
//   resp_valid      1-cycle pulse, resp_price valid (held until next pulse)
//   vip_cnt         saturating count of discounted VIP sales
module vip_discount_store
  import vip_discount_store_pkg::*;
#(
  parameter int unsigned PRICE_W  = PRICE_W_DEF,
  parameter int unsigned OFF_NONE = OFF_NONE_DEF,
  parameter int unsigned CNT_MAX  = CNT_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         wr_cmd,
  input  logic [4:0]         vip_off_i,
  output logic [4:0]         vip_off_o,
  output logic               wr_err,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [PRICE_W-1:0] req_price,
  input  logic               req_is_vip,
  output logic               resp_valid,
  output logic [PRICE_W-1:0] resp_price,
  output logic [6:0]         vip_cnt
);

  localparam int unsigned P_W = PRICE_W + 4;

  state_e         state, state_nxt;
  cmd_e           cmd;
  logic [P_W-1:0] mcand, acc, acc_nxt;
  logic [3:0]     fac_sh, fac_l, fac_sel;
  logic           vip_l;
  logic [1:0]     mul_cnt;
  logic           div_start, div_busy, div_done;
  logic [P_W-1:0] div_q;

  assign cmd     = cmd_e'(wr_cmd);
  assign fac_sel = req_is_vip ? 4'(vip_off_o) : 4'(OFF_NONE);
  assign acc_nxt = acc + (fac_sh[0] ? mcand : '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // The divider is started in the last MUL cycle with the final partial sum,
  // so its 18 steps run in DIV and DONE lands exactly 23 edges after accept.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    div_start  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ST_MUL;
      end
      ST_MUL: begin
        if (mul_cnt == 2'd3) begin
          div_start = 1'b1;
          state_nxt = ST_DIV;
        end
      end
      ST_DIV: begin
        if (div_done) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch and shift-add multiply (LSB of the factor first)
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand      <= '0;
      acc        <= '0;
      fac_sh     <= '0;
      fac_l      <= '0;
      vip_l      <= 1'b0;
      mul_cnt    <= '0;
      resp_price <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            mcand   <= P_W'(req_price);
            acc     <= '0;
            fac_sh  <= fac_sel;
            fac_l   <= fac_sel;
            vip_l   <= req_is_vip;
            mul_cnt <= '0;
          end
        end
        ST_MUL: begin
          acc     <= acc_nxt;
          mcand   <= mcand << 1;
          fac_sh  <= fac_sh >> 1;
          mul_cnt <= mul_cnt + 2'd1;
        end
        ST_DIV: begin
          if (div_done) resp_price <= PRICE_W'(div_q);
        end
        default: ;
      endcase
    end
  end

  div10_serial #(
    .W(P_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .dividend(acc_nxt),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_q)
  );

  // Manager commands and sale counter; revive overrides a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      vip_off_o <= 5'(OFF_NONE);
      wr_err    <= 1'b0;
      vip_cnt   <= '0;
    end else begin
      wr_err <= 1'b0;
      if (en) begin
        case (cmd)
          CMD_SET: begin
            if (off_legal(vip_off_i, 5'(OFF_NONE))) vip_off_o <= vip_off_i;
            else                                    wr_err    <= 1'b1;
          end
          CMD_REV:  vip_off_o <= 5'(OFF_NONE);
          CMD_RSV:  wr_err    <= 1'b1;
          CMD_NONE: ;
          default:  ;
        endcase
      end
      if (en && cmd == CMD_REV) begin
        vip_cnt <= '0;
      end else if (state == ST_DONE && vip_l && fac_l < 4'(OFF_NONE) &&
                   vip_cnt < 7'(CNT_MAX) && !div_busy) begin
        vip_cnt <= vip_cnt + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_vip_discount_store.sv
module tb_vip_discount_store;

  localparam int PW = 14;

  logic          clk = 1'b0;
  logic          rst, en;
  logic [1:0]    wr_cmd;
  logic [4:0]    vip_off_i, vip_off_o;
  logic          wr_err;
  logic          req_valid, req_ready, req_is_vip;
  logic [PW-1:0] req_price, resp_price;
  logic          resp_valid;
  logic [6:0]    vip_cnt;

  always #5 clk = ~clk;

  vip_discount_store #(
    .PRICE_W (14),
    .OFF_NONE(10),
    .CNT_MAX (99)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .wr_cmd    (wr_cmd),
    .vip_off_i (vip_off_i),
    .vip_off_o (vip_off_o),
    .wr_err    (wr_err),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_price (req_price),
    .req_is_vip(req_is_vip),
    .resp_valid(resp_valid),
    .resp_price(resp_price),
    .vip_cnt   (vip_cnt)
  );

  typedef struct {
    int price;
    int due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_err_pulse = 0;
  int   n_resp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin : mon
    exp_t e;
    if (wr_err) n_err_pulse++;
    if (!rst && resp_valid) begin
      n_resp++;
      if (sb.size() == 0) begin
        check("unexpected_resp", 1, 0);
      end else begin
        e = sb.pop_front();
        check("resp_price", int'(resp_price), e.price);
        check("resp_latency", cyc, e.due);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] c, input int off, input logic e);
    en        = e;
    wr_cmd    = c;
    vip_off_i = 5'(off);
    step();
    wr_cmd = 2'b00;
    en     = 1'b1;
  endtask

  task automatic issue(input int price, input logic vip, input int exp, output int k);
    int t;
    t = 0;
    while (!req_ready && t < 100) begin
      step();
      t++;
    end
    if (!req_ready) check("req_ready_timeout", 0, 1);
    req_valid  = 1'b1;
    req_price  = PW'(price);
    req_is_vip = vip;
    step();
    k         = cyc;
    req_valid = 1'b0;
    sb.push_back('{price: exp, due: k + 23});
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      step();
      t++;
    end
    check("drain_timeout", sb.size(), 0);
    step();
    step();
  endtask

  initial begin
    int k;
    int p;
    rst        = 1'b1;
    en         = 1'b1;
    wr_cmd     = 2'b00;
    vip_off_i  = '0;
    req_valid  = 1'b0;
    req_price  = '0;
    req_is_vip = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    check("rst_vip_off", int'(vip_off_o), 10);
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_resp_valid", int'(resp_valid), 0);
    check("rst_resp_price", int'(resp_price), 0);
    check("rst_vip_cnt", int'(vip_cnt), 0);
    check("rst_wr_err", int'(wr_err), 0);

    // 1: no discount yet; non-VIP takes same path
    issue(1000, 1'b1, 1000, k);
    drain();
    check("t1_vip_cnt", int'(vip_cnt), 0);
    check("t1_vip_off", int'(vip_off_o), 10);
    issue(777, 1'b0, 777, k);
    drain();

    // 2: set 8, 1234*8/10 = 987
    send_cmd(2'b11, 8, 1'b1);
    check("t2_vip_off", int'(vip_off_o), 8);
    check("t2_wr_err", int'(wr_err), 0);
    issue(1234, 1'b1, 987, k);
    drain();
    check("t2_vip_cnt", int'(vip_cnt), 1);

    // 3: illegal values and reserved command, back to back
    n_err_pulse = 0;
    en = 1'b1; wr_cmd = 2'b11; vip_off_i = 5'd0;  step();
    vip_off_i = 5'd12; step();
    wr_cmd = 2'b10;    step();
    wr_cmd = 2'b00;
    repeat (3) step();
    check("t3_err_pulses", n_err_pulse, 3);
    check("t3_vip_off", int'(vip_off_o), 8);
    // en=0 ignores everything
    n_err_pulse = 0;
    send_cmd(2'b10, 0, 1'b0);
    send_cmd(2'b11, 3, 1'b0);
    send_cmd(2'b01, 0, 1'b0);
    step();
    check("t3_en0_err", n_err_pulse, 0);
    check("t3_en0_off", int'(vip_off_o), 8);
    check("t3_en0_cnt", int'(vip_cnt), 1);
    // boundary factor 1
    send_cmd(2'b11, 1, 1'b1);
    check("t3_off1", int'(vip_off_o), 1);
    issue(9, 1'b1, 0, k);
    drain();
    issue(9999, 1'b1, 999, k);
    drain();
    check("t3_vip_cnt", int'(vip_cnt), 3);

    // 4: change factor during MUL does not affect the running request
    send_cmd(2'b11, 5, 1'b1);
    issue(9999, 1'b1, 4999, k);
    send_cmd(2'b11, 9, 1'b1);
    check("t4_off_now", int'(vip_off_o), 9);
    drain();
    check("t4_vip_cnt_a", int'(vip_cnt), 4);
    issue(100, 1'b1, 90, k);
    drain();
    check("t4_vip_cnt_b", int'(vip_cnt), 5);

    // 5: revive in the DONE cycle wins over the increment
    issue(200, 1'b1, 180, k);
    while (cyc < k + 23) step();
    check("t5_in_done", int'(resp_valid), 1);
    send_cmd(2'b01, 0, 1'b1);
    check("t5_vip_cnt", int'(vip_cnt), 0);
    check("t5_vip_off", int'(vip_off_o), 10);
    drain();

    // 6: saturation after 100 VIP sales at factor 9
    send_cmd(2'b11, 9, 1'b1);
    for (int i = 0; i < 100; i++) begin
      p = 37 * i + 11;
      issue(p, 1'b1, (p * 9) / 10, k);
    end
    drain();
    check("t6_vip_cnt_sat", int'(vip_cnt), 99);

    // reset during DIV aborts: no response
    issue(500, 1'b1, 450, k);
    while (cyc < k + 10) step();
    rst = 1'b1;
    sb.delete();
    n_resp = 0;
    step();
    rst = 1'b0;
    check("t6_rst_ready", int'(req_ready), 1);
    check("t6_rst_off", int'(vip_off_o), 10);
    check("t6_rst_cnt", int'(vip_cnt), 0);
    check("t6_rst_price", int'(resp_price), 0);
    repeat (30) step();
    check("t6_no_resp", n_resp, 0);
    issue(50, 1'b1, 50, k);
    drain();
    check("t6_after_cnt", int'(vip_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
